// File: rtl/mac_dot_sequencer_if.sv
// Operand-beat stream and result port shared between the MAC sequencer and its neighbours.
// master = issue/operand side and writeback side; slave = the sequencer.
interface mac_dot_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] weight;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    modport master (
        output in_valid, in_data, weight, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_data, weight, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences the 4-lane 8-bit MAC over a stream of beats and returns one 32-bit dot product.
// state | meaning
// IDLE  | waiting for start_i; no beats taken, no result
// RUN   | accepting beats, cnt_q counts remaining beats
// DONE  | result held on res_data_o until res_ready_i
module mac_dot_sequencer #(
    parameter int LEN_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [31:0]          acc_init_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic [LEN_W-1:0]     beats_left_o,
    mac_dot_sequencer_if.slave   bus_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic signed [15:0] prod [4];
    logic signed [17:0] lane_sum;
    logic               accept;

    // Activation zero-extended, weight sign-extended; each product fits in 16 bits signed.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k]  = $signed({8'b0, bus_if.in_data[8*k +: 8]}) *
                       $signed({{8{bus_if.weight[8*k+7]}}, bus_if.weight[8*k +: 8]});
            lane_sum = lane_sum + {{2{prod[k][15]}}, prod[k]};
        end
    end

    assign bus_if.in_ready  = (state_q == RUN) && !abort_i;
    assign bus_if.res_valid = (state_q == DONE);
    assign bus_if.res_data  = (state_q == DONE) ? acc_q : 32'd0;
    assign busy_o           = (state_q != IDLE);
    assign beats_left_o     = cnt_q;
    assign accept           = bus_if.in_valid && bus_if.in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = acc_init_i;
                    cnt_d   = len_i;
                    state_d = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    acc_d = acc_q + {{14{lane_sum[17]}}, lane_sum};
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort_i || bus_if.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: vector table, hand-written corner sequences,
// and randomized operations checked against a plain-arithmetic dot-product model.
module tb_mac_dot_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] len_s;
    logic [31:0] init_s;
    logic        abort;
    logic        busy;
    logic [15:0] beats_left;

    mac_dot_sequencer_if bus ();

    mac_dot_sequencer #(.LEN_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .len_i        (len_s),
        .acc_init_i   (init_s),
        .abort_i      (abort),
        .busy_o       (busy),
        .beats_left_o (beats_left),
        .bus_if       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] beat_in [0:15];
    logic [31:0] beat_w  [0:15];

    typedef struct {
        logic [15:0] len;
        logic [31:0] init;
        logic [31:0] in_d;
        logic [31:0] w_d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Dot product from the arithmetic rules: unsigned activation times signed weight, wrap mod 2^32.
    function automatic logic [31:0] model_dot(input logic [31:0] init, input int len);
        logic [31:0] sum;
        logic [7:0]  a, w;
        int          p;
        sum = init;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 4; k++) begin
                a   = beat_in[i][8*k +: 8];
                w   = beat_w[i][8*k +: 8];
                p   = int'(a) * int'($signed(w));
                sum = sum + 32'(p);
            end
        end
        return sum;
    endfunction

    task automatic do_op(input logic [15:0] len, input logic [31:0] init, input int gap_pct,
                         input int rdy_delay, output logic [31:0] res, output int cycles);
        int idx;
        int guard;
        start  = 1'b1;
        len_s  = len;
        init_s = init;
        tick();
        start  = 1'b0;
        cycles = 1;
        idx    = 0;
        guard  = 0;
        while (idx < int'(len) && guard < 500) begin
            bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.in_data  = beat_in[idx];
            bus.weight   = beat_w[idx];
            check("in_ready_run", {31'b0, bus.in_ready}, 32'd1);
            check("beats_left_run", {16'b0, beats_left}, 32'(int'(len) - idx));
            if (bus.in_valid) idx++;
            tick();
            cycles++;
            guard++;
        end
        if (guard >= 500) check("beat_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        check("res_valid_rise", {31'b0, bus.res_valid}, 32'd1);
        check("in_ready_done", {31'b0, bus.in_ready}, 32'd0);
        check("beats_left_done", {16'b0, beats_left}, 32'd0);
        res = bus.res_data;
        for (int d = 0; d < rdy_delay; d++) begin
            tick();
            cycles++;
            check("res_valid_hold", {31'b0, bus.res_valid}, 32'd1);
            check("res_data_stable", bus.res_data, res);
        end
        bus.res_ready = 1'b1;
        tick();
        cycles++;
        bus.res_ready = 1'b0;
        check("res_valid_fall", {31'b0, bus.res_valid}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic fill_beats(input logic [31:0] d, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            beat_in[i] = d;
            beat_w[i]  = w;
        end
    endtask

    task automatic feed_beats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = beat_in[i];
            bus.weight   = beat_w[i];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int          cyc;
        int          rlen;

        vecs[0] = '{16'd1, 32'h0000_0000, 32'h0403_0201, 32'h0101_0101, 32'd10};
        vecs[1] = '{16'd1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8080_8080, 32'hFFFE_0200};
        vecs[2] = '{16'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h8000_0001};
        vecs[3] = '{16'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1234_5678};
        vecs[4] = '{16'd1, 32'h0000_0000, 32'h80FF_0010, 32'h7F80_FF02, 32'hFFFF_C020};
        vecs[5] = '{16'd3, 32'd100,       32'h0101_0101, 32'hFFFF_FFFF, 32'd88};

        rst = 1'b1; start = 1'b0; len_s = '0; init_s = '0; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.weight = '0; bus.res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_beats_left", {16'b0, beats_left}, 32'd0);
        bus.in_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            fill_beats(vecs[v].in_d, vecs[v].w_d, int'(vecs[v].len));
            do_op(vecs[v].len, vecs[v].init, 0, 0, res, cyc);
            check($sformatf("vec%0d_result", v), res, vecs[v].exp);
            check($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(int'(vecs[v].len) + 2));
        end

        // Wrap case again with valid gaps and a held-off result handshake.
        fill_beats(32'h0000_0001, 32'h0000_0001, 2);
        do_op(16'd2, 32'h7FFF_FFFF, 50, 3, res, cyc);
        check("wrap_backpressure", res, 32'h8000_0001);

        // Abort after two of four beats, with an ignored start pulse in RUN.
        fill_beats(32'h0505_0505, 32'h0303_0303, 4);
        start = 1'b1; len_s = 16'd4; init_s = 32'd7;
        tick();
        start = 1'b0;
        feed_beats(2);
        check("abort_pre_left", {16'b0, beats_left}, 32'd2);
        start = 1'b1; len_s = 16'd9; init_s = 32'd0;
        tick();
        start = 1'b0;
        check("start_ignored_left", {16'b0, beats_left}, 32'd2);
        check("start_ignored_busy", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("abort_gates_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("abort_left", {16'b0, beats_left}, 32'd0);
        fill_beats(32'h0A0B_0C0D, 32'hF102_F304, 1);
        do_op(16'd1, 32'h0000_0000, 0, 0, res, cyc);
        check("after_abort_result", res, model_dot(32'h0, 1));

        // start wins over abort in IDLE; then abort the run it launched.
        start = 1'b1; abort = 1'b1; len_s = 16'd1; init_s = 32'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_beats_abort_busy", {31'b0, busy}, 32'd1);
        check("start_beats_abort_left", {16'b0, beats_left}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run_idle", {31'b0, busy}, 32'd0);

        // Synchronous reset with three beats remaining.
        fill_beats(32'h7F7F_7F7F, 32'h7F7F_7F7F, 5);
        start = 1'b1; len_s = 16'd5; init_s = 32'h5555_0000;
        tick();
        start = 1'b0;
        feed_beats(2);
        check("pre_rst_left", {16'b0, beats_left}, 32'd3);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("midrst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("midrst_res_data", bus.res_data, 32'd0);
        check("midrst_left", {16'b0, beats_left}, 32'd0);
        fill_beats(32'h0000_0003, 32'h0000_00FE, 1);
        do_op(16'd1, 32'h0000_0000, 0, 0, res, cyc);
        check("after_rst_result", res, 32'hFFFF_FFFA);

        // Randomized operations against the arithmetic model.
        for (int t = 0; t < 25; t++) begin
            rlen = $urandom_range(0, 8);
            for (int i = 0; i < rlen; i++) begin
                beat_in[i] = $urandom;
                beat_w[i]  = $urandom;
            end
            init_s = $urandom;
            do_op(16'(rlen), init_s, $urandom_range(0, 40), $urandom_range(0, 3), res, cyc);
            check($sformatf("rand%0d_result", t), res, model_dot(init_s, rlen));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
